// File: rtl/tex_addr_pkg.sv
// rtl/tex_addr_pkg.sv - shared format/wrap codes, widths and stride lookup for texture address generation
package tex_addr_pkg;

  // Texel format codes
  localparam logic [2:0] FMT_A8R8G8B8 = 3'd0;
  localparam logic [2:0] FMT_R5G6B5   = 3'd1;
  localparam logic [2:0] FMT_A1R5G5B5 = 3'd2;
  localparam logic [2:0] FMT_A4R4G4B4 = 3'd3;
  localparam logic [2:0] FMT_A8L8     = 3'd4;
  localparam logic [2:0] FMT_L8       = 3'd5;
  localparam logic [2:0] FMT_A8       = 3'd6;

  // Wrap mode codes; code 3 falls back to clamp
  localparam logic [1:0] WRAP_CLAMP  = 2'd0;
  localparam logic [1:0] WRAP_REPEAT = 2'd1;
  localparam logic [1:0] WRAP_MIRROR = 2'd2;

  // Texels per bilinear footprint and blend weight width
  localparam int TEXELS   = 4;
  localparam int WEIGHT_W = 8;

  // Coordinate math is 32-bit signed widened by 16 bits so the shift by logdim cannot overflow
  localparam int IDX_W       = 48;
  // Wrapped indices are below 2^15; one spare bit keeps mirror/clamp results unambiguous
  localparam int TEXEL_IDX_W = 16;

  function automatic logic [1:0] fmt_log_stride(input logic [2:0] fmt);
    case (fmt)
      FMT_A8R8G8B8: return 2'd2;
      FMT_R5G6B5, FMT_A1R5G5B5, FMT_A4R4G4B4, FMT_A8L8: return 2'd1;
      FMT_L8, FMT_A8: return 2'd0;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tex_wrap.sv
// rtl/tex_wrap.sv - combinational single-axis texel index wrap (clamp/repeat/mirror)
module tex_wrap
  import tex_addr_pkg::*;
#(
  parameter int LOG_DIM_BITS = 4
) (
  input  logic signed [IDX_W-1:0]       idx,
  input  logic        [LOG_DIM_BITS-1:0] logdim,
  input  logic        [1:0]              mode,
  output logic        [TEXEL_IDX_W-1:0]  wrapped
);

  logic signed [IDX_W-1:0] dim;
  logic signed [IDX_W-1:0] span;
  logic signed [IDX_W-1:0] m;
  logic signed [IDX_W-1:0] res;
  logic                    unused_res_hi;

  // Dimensions are powers of two, so modulo reduces to masking in two's complement
  always_comb begin
    dim  = IDX_W'(1) << logdim;
    span = dim << 1;
    m    = idx & (span - IDX_W'(1));
    case (mode)
      WRAP_REPEAT: res = idx & (dim - IDX_W'(1));
      WRAP_MIRROR: res = (m >= dim) ? (span - IDX_W'(1) - m) : m;
      default: begin
        if (idx < 0)
          res = '0;
        else if (idx > dim - IDX_W'(1))
          res = dim - IDX_W'(1);
        else
          res = idx;
      end
    endcase
  end

  assign wrapped       = res[TEXEL_IDX_W-1:0];
  assign unused_res_hi = ^res[IDX_W-1:TEXEL_IDX_W];

endmodule

// File: rtl/tex_addr_gen.sv
// rtl/tex_addr_gen.sv - 2-stage elastic texel address generator; TEX_ADDR_PERF_EN adds perf_stall_cycles
module tex_addr_gen
  import tex_addr_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int TAG_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int FXD_FRAC     = 20,
  parameter int LOG_DIM_BITS = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [NUM_LANES-1:0]                  req_mask,
  input  logic [NUM_LANES*32-1:0]               req_u,
  input  logic [NUM_LANES*32-1:0]               req_v,
  input  logic [2:0]                            req_format,
  input  logic                                  req_filter,
  input  logic [1:0]                            req_wrap_u,
  input  logic [1:0]                            req_wrap_v,
  input  logic [LOG_DIM_BITS-1:0]               req_logwidth,
  input  logic [LOG_DIM_BITS-1:0]               req_logheight,
  input  logic [ADDR_WIDTH-1:0]                 req_baseaddr,
  input  logic [TAG_WIDTH-1:0]                  req_tag,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [NUM_LANES-1:0]                  rsp_mask,
  output logic [NUM_LANES*TEXELS*ADDR_WIDTH-1:0] rsp_addr,
  output logic [NUM_LANES*WEIGHT_W-1:0]         rsp_alpha,
  output logic [NUM_LANES*WEIGHT_W-1:0]         rsp_beta,
  output logic [2:0]                            rsp_format,
  output logic [TAG_WIDTH-1:0]                  rsp_tag
`ifdef TEX_ADDR_PERF_EN
  , output logic [31:0]                         perf_stall_cycles
`endif
);

  localparam logic signed [IDX_W-1:0] HALF = IDX_W'(1) << (FXD_FRAC - 1);

  logic en0, en1, v0;

  logic signed [IDX_W-1:0] s_u  [NUM_LANES];
  logic signed [IDX_W-1:0] s_v  [NUM_LANES];
  logic signed [IDX_W-1:0] i0_u [NUM_LANES];
  logic signed [IDX_W-1:0] i1_u [NUM_LANES];
  logic signed [IDX_W-1:0] i0_v [NUM_LANES];
  logic signed [IDX_W-1:0] i1_v [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  x0_w [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  x1_w [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  y0_w [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  y1_w [NUM_LANES];
  logic [NUM_LANES*WEIGHT_W-1:0] alpha_c, beta_c;

  logic [TEXEL_IDX_W-1:0]  s0_x0 [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  s0_x1 [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  s0_y0 [NUM_LANES];
  logic [TEXEL_IDX_W-1:0]  s0_y1 [NUM_LANES];
  logic [NUM_LANES-1:0]    s0_mask;
  logic [NUM_LANES*WEIGHT_W-1:0] s0_alpha, s0_beta;
  logic [2:0]              s0_format;
  logic [LOG_DIM_BITS-1:0] s0_logwidth;
  logic [ADDR_WIDTH-1:0]   s0_base;
  logic [TAG_WIDTH-1:0]    s0_tag;

  logic [NUM_LANES*TEXELS*ADDR_WIDTH-1:0] addr_c;
  logic [ADDR_WIDTH-1:0]   off;

  assign en1       = !rsp_valid || rsp_ready;
  assign en0       = !v0 || en1;
  assign req_ready = en0;

  // Stage 0 math: scale to texel space, bias by half a texel for bilinear, split integer/weight
  always_comb begin
    s_u = '{default: '0};
    s_v = '{default: '0};
    i0_u = '{default: '0};
    i1_u = '{default: '0};
    i0_v = '{default: '0};
    i1_v = '{default: '0};
    alpha_c = '0;
    beta_c  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      s_u[l] = ($signed({{(IDX_W-32){req_u[l*32+31]}}, req_u[l*32 +: 32]}) <<< req_logwidth)
               - (req_filter ? HALF : '0);
      s_v[l] = ($signed({{(IDX_W-32){req_v[l*32+31]}}, req_v[l*32 +: 32]}) <<< req_logheight)
               - (req_filter ? HALF : '0);
      i0_u[l] = s_u[l] >>> FXD_FRAC;
      i0_v[l] = s_v[l] >>> FXD_FRAC;
      i1_u[l] = req_filter ? i0_u[l] + IDX_W'(1) : i0_u[l];
      i1_v[l] = req_filter ? i0_v[l] + IDX_W'(1) : i0_v[l];
      alpha_c[l*WEIGHT_W +: WEIGHT_W] = (req_filter && req_mask[l]) ? s_u[l][FXD_FRAC-1 -: WEIGHT_W] : '0;
      beta_c[l*WEIGHT_W +: WEIGHT_W]  = (req_filter && req_mask[l]) ? s_v[l][FXD_FRAC-1 -: WEIGHT_W] : '0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tex_wrap #(.LOG_DIM_BITS(LOG_DIM_BITS)) u_wrap_x0 (
      .idx(i0_u[g]), .logdim(req_logwidth), .mode(req_wrap_u), .wrapped(x0_w[g]));
    tex_wrap #(.LOG_DIM_BITS(LOG_DIM_BITS)) u_wrap_x1 (
      .idx(i1_u[g]), .logdim(req_logwidth), .mode(req_wrap_u), .wrapped(x1_w[g]));
    tex_wrap #(.LOG_DIM_BITS(LOG_DIM_BITS)) u_wrap_y0 (
      .idx(i0_v[g]), .logdim(req_logheight), .mode(req_wrap_v), .wrapped(y0_w[g]));
    tex_wrap #(.LOG_DIM_BITS(LOG_DIM_BITS)) u_wrap_y1 (
      .idx(i1_v[g]), .logdim(req_logheight), .mode(req_wrap_v), .wrapped(y1_w[g]));
  end

  // Stage 0 register: wrapped indices and weights, advanced whenever stage 1 can take its contents
  always_ff @(posedge clk) begin
    if (reset) begin
      v0          <= 1'b0;
      s0_mask     <= '0;
      s0_alpha    <= '0;
      s0_beta     <= '0;
      s0_format   <= '0;
      s0_logwidth <= '0;
      s0_base     <= '0;
      s0_tag      <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        s0_x0[l] <= '0;
        s0_x1[l] <= '0;
        s0_y0[l] <= '0;
        s0_y1[l] <= '0;
      end
    end else if (en0) begin
      v0 <= req_valid;
      if (req_valid) begin
        s0_mask     <= req_mask;
        s0_alpha    <= alpha_c;
        s0_beta     <= beta_c;
        s0_format   <= req_format;
        s0_logwidth <= req_logwidth;
        s0_base     <= req_baseaddr;
        s0_tag      <= req_tag;
        for (int l = 0; l < NUM_LANES; l++) begin
          s0_x0[l] <= x0_w[l];
          s0_x1[l] <= x1_w[l];
          s0_y0[l] <= y0_w[l];
          s0_y1[l] <= y1_w[l];
        end
      end
    end
  end

  // Stage 1 math: linear texel offset scaled by format stride; texel t uses x1 when t[0], y1 when t[1]
  always_comb begin
    addr_c = '0;
    off    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int t = 0; t < TEXELS; t++) begin
        off = ((ADDR_WIDTH'(((t & 2) != 0) ? s0_y1[l] : s0_y0[l]) << s0_logwidth)
               + ADDR_WIDTH'(((t & 1) != 0) ? s0_x1[l] : s0_x0[l])) << fmt_log_stride(s0_format);
        if (s0_mask[l])
          addr_c[(l*TEXELS+t)*ADDR_WIDTH +: ADDR_WIDTH] = s0_base + off;
      end
    end
  end

  // Stage 1 register: response holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_mask   <= '0;
      rsp_addr   <= '0;
      rsp_alpha  <= '0;
      rsp_beta   <= '0;
      rsp_format <= '0;
      rsp_tag    <= '0;
    end else if (en1) begin
      rsp_valid <= v0;
      if (v0) begin
        rsp_mask   <= s0_mask;
        rsp_addr   <= addr_c;
        rsp_alpha  <= s0_alpha;
        rsp_beta   <= s0_beta;
        rsp_format <= s0_format;
        rsp_tag    <= s0_tag;
      end
    end
  end

`ifdef TEX_ADDR_PERF_EN
  // Count cycles where a response is presented but not taken
  always_ff @(posedge clk) begin
    if (reset)
      perf_stall_cycles <= '0;
    else if (rsp_valid && !rsp_ready)
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/tex_addr_gen.md
Name: tex_addr_gen

Overview:
Texture address generation stage directly upstream of the texel memory request unit. Per lane, it converts fixed-point (u,v) into bilinear or point texel indices and applies the wrap mode. It then derives the format's log2 texel stride and emits four byte addresses per lane plus the blend weights. The datapath is a 2-stage elastic pipeline with a valid/ready interface on both sides.

Parameters:
NUM_LANES, 4, lanes per request
TAG_WIDTH, 8, opaque request tag width
ADDR_WIDTH, 32, byte address width
FXD_FRAC, 20, fraction bits of the signed 32-bit coordinates
LOG_DIM_BITS, 4, width of the log2 width/height fields (dimensions up to 2^15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_mask  in  NUM_LANES  active lanes
req_u, req_v  in  NUM_LANES*32  signed fixed-point coordinates
req_format  in  3  texel format code
req_filter  in  1  0=point, 1=bilinear
req_wrap_u, req_wrap_v  in  2  0=CLAMP, 1=REPEAT, 2=MIRROR
req_logwidth, req_logheight  in  LOG_DIM_BITS  log2 dimensions
req_baseaddr  in  ADDR_WIDTH  mip base byte address
req_tag  in  TAG_WIDTH  tag
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
rsp_mask  out  NUM_LANES  passthrough mask
rsp_addr  out  NUM_LANES*4*ADDR_WIDTH  texel order: (x0,y0),(x1,y0),(x0,y1),(x1,y1)
rsp_alpha, rsp_beta  out  NUM_LANES*8  u and v blend weights
rsp_format  out  3  passthrough format
rsp_tag  out  TAG_WIDTH  passthrough tag

Behaviour:
- Clock/reset are fixed: single clock `clk`; `reset` is synchronous and active-high.
- Reset: both stage valids are 0; rsp_valid=0; all rsp data=0; req_ready=1 in the cycle after reset deasserts. Reset mid-operation discards in-flight requests.
- Stage enable: enN = !validN || enN+1, with en_out = rsp_ready. req_ready = en0, which is combinational from rsp_ready through the stages.
- Throughput is 1 request/cycle. Latency is 2 cycles from acceptance to rsp_valid with no backpressure. Order is preserved. Held outputs stay stable while rsp_valid && !rsp_ready.
- Stage 0, per lane and axis. Computation is signed, widened 16 bits to avoid overflow.
  - s = (c << logdim) - (filter ? 1<<(FXD_FRAC-1) : 0)
  - i0 = s >>> FXD_FRAC
  - i1 = filter ? i0+1 : i0
  - weight = filter ? s[FXD_FRAC-1 -: 8] : 0
- Wrap, with D = 1<<logdim:
  - CLAMP: clamp to [0, D-1], including negative values.
  - REPEAT: i & (D-1).
  - MIRROR: m = i mod 2D (non-negative); result = (m >= D) ? 2D-1-m : m.
  - Wrap code 3 is treated as CLAMP.
- Stage 1: addr = baseaddr + ((y*D_w + x) << log_stride), computed modulo 2^ADDR_WIDTH. y*D_w is implemented as y << logwidth.
- log_stride by format:
  - A8R8G8B8 → 2
  - R5G6B5, A1R5G5B5, A4R4G4B4, A8L8 → 1
  - L8, A8 → 0
  - Undefined codes → 0
- Lanes with mask=0 output addr=0 and weights=0.

Optional Feature:
TEX_ADDR_PERF_EN
- Defined: adds output `perf_stall_cycles` (32-bit). It counts cycles with rsp_valid && !rsp_ready, wraps at 2^32, and resets to 0.
- Undefined: the port and counter do not exist.

Decomposition:
- Shared package tex_addr_pkg holds:
  - Format codes: A8R8G8B8=0, R5G6B5=1, A1R5G5B5=2, A4R4G4B4=3, A8L8=4, L8=5, A8=6.
  - Wrap codes, and constants for texel count (4) and weight width (8).
- One sub-module, tex_wrap: a combinational single-axis wrap (index, logdim, mode → wrapped index), instantiated 4×NUM_LANES.

Test Plan:
1. L8, point, REPEAT, log 4/4, u=v=0x00080000, base 0x1000 → all 4 lane addrs = 0x1088; alpha=beta=0; rsp_valid exactly 2 cycles after acceptance.
2. A8R8G8B8, bilinear, CLAMP, log 2/2, u=v=0 → s=-0.5: i0=-1→0, i1=0; all addrs = base; alpha=beta=0x80.
3. R5G6B5, bilinear, REPEAT, logwidth 2, logheight 0, u=1.0, v=0 → x0=3, x1=0, y0=y1=0; addrs base+6, base+0, base+6, base+0; alpha=0x80.
4. L8, point, MIRROR, logwidth 2, u=1.25 (0x00140000), v=0 → x=2; addr base+2. Lane 1 with mask=0 → addr 0.
5. Three back-to-back requests with rsp_ready low for 3 cycles → req_ready drops once both stages are full; responses arrive in order with no loss; perf_stall_cycles=3 when TEX_ADDR_PERF_EN is defined.
6. Assert reset with both stages valid → rsp_valid=0 next cycle; the next request after reset appears 2 cycles after acceptance.
